mux_nto1_reg_arb: RTL and testbench

//  Registered N-input, WIDTH-bit multiplexer with valid/ready handshake on every input and the output.

---
 rtl/mux_nto1_reg_arb_pkg.sv | 14 +
 rtl/mux_nto1_reg_arb_if.sv | 25 ++
 rtl/mux_nto1_reg_arb_rr_arbiter.sv | 39 +++
 rtl/mux_nto1_reg_arb.sv | 89 ++++++++
 tb/tb_mux_nto1_reg_arb.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/mux_nto1_reg_arb_pkg.sv
// Shared constants and helpers for the registered N:1 mux with select/arbitration modes.
package mux_nto1_reg_arb_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_nto1_reg_arb_if.sv
// Channel-side and output-side handshake bundle for mux_nto1_reg_arb.
interface mux_nto1_reg_arb_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_src;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/mux_nto1_reg_arb_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr, ptr moves past each granted index on advance.
module rr_arbiter
    import mux_nto1_reg_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [SEL_W-1:0] ptr;

    // Walk offsets from farthest to nearest so the closest requester to ptr wins.
    always_comb begin
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int i = 0; i < N; i++) begin
                if (((int'(ptr) + k) % N) == i && req[i]) begin
                    gnt_idx = SEL_W'(i);
                end
            end
        end
        gnt_valid = |req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_nto1_reg_arb.sv
// Registered N-input mux with valid/ready on every channel; explicit select or round-robin grant.
module mux_nto1_reg_arb
    import mux_nto1_reg_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_nto1_reg_arb_if.slave   bus
);

    if (N < 2) begin : g_chk_n
        $error("mux_nto1_reg_arb: N must be >= 2");
    end
    if (SEL_W < clog2(N)) begin : g_chk_sel_w
        $error("mux_nto1_reg_arb: SEL_W too narrow for N");
    end
    if (MODE != MODE_SEL && MODE != MODE_RR) begin : g_chk_mode
        $error("mux_nto1_reg_arb: MODE must be 0 or 1");
    end

    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             load;
    logic [WIDTH-1:0] gnt_data;
    logic [N-1:0]     ready;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] src_q;
    logic             valid_q;

    if (MODE == MODE_RR) begin : g_rr
        rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (bus.in_valid),
            .advance   (load),
            .gnt_idx   (gnt_idx),
            .gnt_valid (gnt_valid)
        );
        logic unused_sel;
        assign unused_sel = ^bus.sel;
    end else begin : g_sel
        // Out-of-range selects fall back to channel 0.
        always_comb begin
            gnt_idx   = (32'(bus.sel) < N) ? bus.sel : '0;
            gnt_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (32'(gnt_idx) == i && bus.in_valid[i]) gnt_valid = 1'b1;
            end
        end
    end

    // Gating with rst_n keeps every in_ready low while reset is held.
    assign load = rst_n && (!valid_q || bus.out_ready) && gnt_valid;

    always_comb begin
        gnt_data = '0;
        ready    = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(gnt_idx) == i) begin
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
                ready[i] = load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= gnt_data;
            src_q   <= gnt_idx;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_nto1_reg_arb.sv
// Directed bench: explicit-select (2- and 3-bit sel) and round-robin instances on a shared clock/reset.
module tb_mux_nto1_reg_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    int rr_seq [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

    mux_nto1_reg_arb_if #(.WIDTH(32), .N(4), .SEL_W(2)) b0 ();
    mux_nto1_reg_arb_if #(.WIDTH(32), .N(4), .SEL_W(3)) b1 ();
    mux_nto1_reg_arb_if #(.WIDTH(32), .N(4), .SEL_W(2)) b2 ();

    mux_nto1_reg_arb #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(0)) u_sel (
        .clk(clk), .rst_n(rst_n), .bus(b0));
    mux_nto1_reg_arb #(.WIDTH(32), .N(4), .SEL_W(3), .MODE(0)) u_wide (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    mux_nto1_reg_arb #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b0.in_data = '0; b0.in_valid = 4'b1111; b0.sel = 2'd0; b0.out_ready = 1'b1;
        b1.in_data = '0; b1.in_valid = 4'b1111; b1.sel = 3'd0; b1.out_ready = 1'b1;
        b2.in_data = '0; b2.in_valid = 4'b1111; b2.sel = 2'd0; b2.out_ready = 1'b1;
        repeat (2) step();
        check("rst_sel_valid", 64'(b0.out_valid), 64'h0);
        check("rst_sel_rdy",   64'(b0.in_ready),  64'h0);
        check("rst_rr_valid",  64'(b2.out_valid), 64'h0);
        check("rst_rr_data",   64'(b2.out_data),  64'h0);
        check("rst_rr_src",    64'(b2.out_src),   64'h0);
        check("rst_rr_rdy",    64'(b2.in_ready),  64'h0);
        b0.in_valid = 4'b0000; b1.in_valid = 4'b0000; b2.in_valid = 4'b0000;
        rst_n = 1'b1;
        step();

        // explicit select of channel 2
        b0.sel = 2'd2; b0.in_valid = 4'b0100; b0.in_data[64 +: 32] = 32'hDEAD_BEEF;
        #1 check("sel2_rdy", 64'(b0.in_ready), 64'h4);
        step();
        check("sel2_data",  64'(b0.out_data),  64'hDEAD_BEEF);
        check("sel2_src",   64'(b0.out_src),   64'h2);
        check("sel2_valid", 64'(b0.out_valid), 64'h1);
        b0.in_valid = 4'b0000;
        step();
        check("sel_drain_valid", 64'(b0.out_valid), 64'h0);

        // backpressure on channel 1
        b0.sel = 2'd1; b0.in_valid = 4'b0010; b0.in_data[32 +: 32] = 32'h1111_1111;
        step();
        check("bp_first_data", 64'(b0.out_data), 64'h1111_1111);
        b0.out_ready = 1'b0; b0.in_data[32 +: 32] = 32'h2222_2222;
        for (int c = 0; c < 3; c++) begin
            #1 check("bp_rdy", 64'(b0.in_ready), 64'h0);
            step();
            check("bp_hold_data",  64'(b0.out_data),  64'h1111_1111);
            check("bp_hold_src",   64'(b0.out_src),   64'h1);
            check("bp_hold_valid", 64'(b0.out_valid), 64'h1);
        end
        b0.out_ready = 1'b1;
        #1 check("bp_release_rdy", 64'(b0.in_ready), 64'h2);
        step();
        check("bp_next_data",  64'(b0.out_data),  64'h2222_2222);
        check("bp_next_valid", 64'(b0.out_valid), 64'h1);
        b0.in_valid = 4'b0000;

        // out-of-range select on the 3-bit variant
        b1.sel = 3'd5; b1.in_valid = 4'b0001; b1.in_data[0 +: 32] = 32'hA5A5_0000;
        #1 check("oor_rdy", 64'(b1.in_ready), 64'h1);
        step();
        check("oor_src",  64'(b1.out_src),  64'h0);
        check("oor_data", 64'(b1.out_data), 64'hA5A5_0000);
        b1.in_valid = 4'b0010;
        #1 check("oor_ch1_wait_rdy", 64'(b1.in_ready), 64'h0);
        step();
        check("oor_ch1_wait_valid", 64'(b1.out_valid), 64'h0);
        b1.in_valid = 4'b0000;

        // round-robin with every channel valid
        for (int i = 0; i < 4; i++) b2.in_data[i*32 +: 32] = 32'hC000_0000 + 32'(i);
        b2.in_valid = 4'b1111; b2.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1 check("rr_rdy", 64'(b2.in_ready), 64'(1 << rr_seq[k]));
            step();
            check("rr_src",  64'(b2.out_src),  64'(rr_seq[k]));
            check("rr_data", 64'(b2.out_data), 64'(32'hC000_0000 + 32'(rr_seq[k])));
        end

        // move ptr to 2, then sparse requests 1010
        b2.in_valid = 4'b0010;
        #1 check("rr_p2_rdy", 64'(b2.in_ready), 64'h2);
        step();
        check("rr_p2_src", 64'(b2.out_src), 64'h1);
        b2.in_valid = 4'b1010;
        #1 check("rr_sp_rdy3", 64'(b2.in_ready), 64'h8);
        step();
        check("rr_sp_src3",  64'(b2.out_src),  64'h3);
        check("rr_sp_data3", 64'(b2.out_data), 64'hC000_0003);
        #1 check("rr_sp_rdy1", 64'(b2.in_ready), 64'h2);
        step();
        check("rr_sp_src1", 64'(b2.out_src), 64'h1);
        b2.out_ready = 1'b0; b2.in_valid = 4'b0010; b2.in_data[32 +: 32] = 32'hDEAD_0001;
        #1 check("rr_hold_rdy", 64'(b2.in_ready), 64'h0);
        for (int c = 0; c < 2; c++) begin
            step();
            check("rr_hold_src",   64'(b2.out_src),   64'h1);
            check("rr_hold_data",  64'(b2.out_data),  64'hC000_0001);
            check("rr_hold_valid", 64'(b2.out_valid), 64'h1);
        end
        b2.in_valid = 4'b1111; b2.out_ready = 1'b1; b2.in_data[32 +: 32] = 32'hC000_0001;
        #1 check("rr_ptr2_rdy", 64'(b2.in_ready), 64'h4);
        step();
        check("rr_ptr2_src", 64'(b2.out_src), 64'h2);

        // reset in the middle of a burst
        b0.sel = 2'd2; b0.in_valid = 4'b0100;
        repeat (2) step();
        check("mid_pre_valid", 64'(b2.out_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",     64'(b2.out_valid), 64'h0);
        check("mid_rst_data",      64'(b2.out_data),  64'h0);
        check("mid_rst_src",       64'(b2.out_src),   64'h0);
        check("mid_rst_rdy",       64'(b2.in_ready),  64'h0);
        check("mid_rst_sel_rdy",   64'(b0.in_ready),  64'h0);
        check("mid_rst_sel_valid", 64'(b0.out_valid), 64'h0);
        step();
        rst_n = 1'b1;
        #1 check("post_rst_rdy", 64'(b2.in_ready), 64'h1);
        step();
        check("post_rst_src",  64'(b2.out_src),  64'h0);
        check("post_rst_data", 64'(b2.out_data), 64'hC000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
